// File: rtl/guess_pkg.sv
// Shared types and helpers for the guessing-game button conditioner.
package guess_pkg;

  localparam int N_BTN = 4;

  typedef logic [N_BTN-1:0] btn_vec_t;

  typedef enum logic [1:0] {IDLE, ARM_P, HELD, ARM_R} deb_state_t;

  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/guess_btn_cond_debounce.sv
// One button channel: 2-flop synchroniser, counter debounce FSM and
// registered press/release pulses. db_next exposes the level about to load.
module btn_debounce
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db,
  output logic db_next,
  output logic press,
  output logic release_p
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic       s1, s2;
  deb_state_t state;
  logic [CW-1:0] cnt;
  logic       term;

  assign term = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Level changes only on the terminal sample of an arming phase.
  assign db_next = (state == ARM_P && s2 && term) ? 1'b1 :
                   (state == ARM_R && !s2 && term) ? 1'b0 : db;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      db        <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      db        <= db_next;
      press     <= db_next & ~db;
      release_p <= ~db_next & db;
      case (state)
        IDLE: if (s2) begin
          state <= ARM_P;
          cnt   <= CW'(1);
        end
        ARM_P: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (term) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: if (!s2) begin
          state <= ARM_R;
          cnt   <= CW'(1);
        end
        ARM_R: begin
          if (s2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (term) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/guess_btn_cond.sv
// Button front end for the guessing game: per-channel debounce plus a
// multi-press flag. Optional anti-cheat lock via GUESS_ONEHOT_LOCK_EN.
module guess_btn_cond #(
  parameter int N_BTN           = guess_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] b,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_p,
  output logic             multi
);

  logic [N_BTN-1:0] db, db_next, press_raw;
  logic             multi_next;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw[i]),
      .db        (db[i]),
      .db_next   (db_next[i]),
      .press     (press_raw[i]),
      .release_p (release_p[i])
    );
  end

  assign multi_next = (guess_pkg::count_ones(32'(db_next)) >= 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) multi <= 1'b0;
    else        multi <= multi_next;
  end

`ifdef GUESS_ONEHOT_LOCK_EN
  // Any press landing while multi is high is swallowed, so a button
  // uncovered by another's release never produces a late press.
  logic [N_BTN-1:0] b_lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) b_lock <= '0;
    else        b_lock <= multi_next ? '0 : db_next;
  end

  assign b     = b_lock;
  assign press = press_raw & ~{N_BTN{multi}};
`else
  assign b     = db;
  assign press = press_raw;
`endif

endmodule

// File: tb/tb_guess_btn_cond.sv
// Directed self-checking bench for guess_btn_cond (DEBOUNCE_CYCLES=4).
module tb_guess_btn_cond;

`ifdef GUESS_ONEHOT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] b, press, release_p;
  logic       multi;

  int checks = 0;
  int failures = 0;

  guess_btn_cond #(.N_BTN(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .b         (b),
    .press     (press),
    .release_p (release_p),
    .multi     (multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int np, nr, npr;
    logic [3:0] acc;

    // 1: press held through reset release
    reset   = 1'b0;
    btn_raw = 4'b0001;
    step();
    chk("rst_b", 32'(b), 0);
    chk("rst_press", 32'(press), 0);
    chk("rst_rel", 32'(release_p), 0);
    chk("rst_multi", 32'(multi), 0);
    step();
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 5) chk("t1_b_early", 32'(b), 0);
      if (i == 6) begin
        chk("t1_b", 32'(b), 32'h1);
        chk("t1_press", 32'(press), 32'h1);
      end
      if (i == 7) begin
        chk("t1_press_off", 32'(press), 0);
        chk("t1_b_hold", 32'(b), 32'h1);
      end
    end
    btn_raw = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 5) chk("t1_rel_early", 32'(b), 32'h1);
      if (i == 6) begin
        chk("t1_rel_b", 32'(b), 0);
        chk("t1_rel_p", 32'(release_p), 32'h1);
      end
      if (i == 7) chk("t1_rel_off", 32'(release_p), 0);
    end

    // 2: three-cycle glitch is rejected
    btn_raw = 4'b0100;
    step(3);
    btn_raw = 4'b0000;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      acc |= b | press | release_p;
    end
    chk("t2_glitch", 32'(acc), 0);

    // 3: long hold, single press and single release
    btn_raw = 4'b1000;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      np += int'(press[3]);
    end
    chk("t3_npress", 32'(np), 1);
    chk("t3_b", 32'(b), 32'h8);
    btn_raw = 4'b0000;
    nr = 0;
    npr = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      nr  += int'(release_p[3]);
      npr += int'(press[3]);
      if (i == 5) chk("t3_b_early", 32'(b), 32'h8);
      if (i == 6) chk("t3_b_rel", 32'(b), 0);
    end
    chk("t3_nrel", 32'(nr), 1);
    chk("t3_no_press", 32'(npr), 0);

    // 4: second button while one is held
    btn_raw = 4'b0010;
    step(6);
    chk("t4_b1", 32'(b), 32'h2);
    chk("t4_multi0", 32'(multi), 0);
    btn_raw = 4'b0011;
    step(5);
    chk("t4_multi_early", 32'(multi), 0);
    step();
    chk("t4_multi", 32'(multi), 1);
    chk("t4_b2", 32'(b), LOCK ? 32'h0 : 32'h3);
    chk("t4_press", 32'(press), LOCK ? 32'h0 : 32'h1);
    step();
    chk("t4_multi_hold", 32'(multi), 1);
    btn_raw = 4'b0001;
    step(6);
    chk("t4_multi_off", 32'(multi), 0);
    chk("t4_b_resume", 32'(b), 32'h1);
    chk("t4_no_press", 32'(press), 0);
    chk("t4_rel", 32'(release_p), 32'h2);
    btn_raw = 4'b0000;
    step(8);
    chk("t4_b_clear", 32'(b), 0);

    // 5: bounce on bit 1
    np = 0;
    btn_raw = 4'b0010; step(); np += int'(press[1]);
    btn_raw = 4'b0000; step(); np += int'(press[1]);
    btn_raw = 4'b0010; step(); np += int'(press[1]);
    btn_raw = 4'b0000; step(); np += int'(press[1]);
    btn_raw = 4'b0010;
    for (int i = 1; i <= 10; i++) begin
      step();
      np += int'(press[1]);
      if (i == 5) chk("t5_b_early", 32'(b), 0);
      if (i == 6) chk("t5_b", 32'(b), 32'h2);
    end
    chk("t5_npress", 32'(np), 1);
    btn_raw = 4'b0000;
    step(8);

    // 6: reset while bit 2 is arming (cnt=2) and bit 0 is held
    btn_raw = 4'b0001;
    step(8);
    chk("t6_pre_b", 32'(b), 32'h1);
    btn_raw = 4'b0101;
    step(4);
    chk("t6_cnt_pre", 32'(dut.g_ch[2].u_deb.cnt), 2);
    reset = 1'b0;
    #1;
    chk("t6_b_rst", 32'(b), 0);
    chk("t6_cnt_rst", 32'(dut.g_ch[2].u_deb.cnt), 0);
    step(2);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) chk("t6_b_early", 32'(b), 0);
      if (i == 6) begin
        chk("t6_b", 32'(b), LOCK ? 32'h0 : 32'h5);
        chk("t6_multi", 32'(multi), 1);
        chk("t6_press", 32'(press), LOCK ? 32'h0 : 32'h5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_btn_cond.md
Name: guess_btn_cond

Overview:
- Player-side front end for the guessing-game FSM.
- Takes the raw, asynchronous push-buttons and produces the clean, synchronous 4-bit button vector `b` that the game FSM consumes.
- Per button: 2-flop synchroniser, counter-based debounce, one-cycle press pulse.
- Also flags multiple simultaneous presses.

Parameters:
- N_BTN, 4, number of buttons; equals the width of the game's `b` input.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a level change is accepted. Use 4 in simulation and 1_000_000 on the board. Legal values ≥ 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw button levels, asynchronous to clk, 1 = pressed.
- b  output  N_BTN  debounced button levels; drives the game FSM `b`.
- press  output  N_BTN  one-cycle pulse per bit when that bit of `b` goes 0→1.
- release_p  output  N_BTN  one-cycle pulse per bit when that bit of `b` goes 1→0.
- multi  output  1  high while two or more bits of the debounced vector are 1.

Behaviour:
- **Reset** (reset=0, asynchronous, immediate):
  - sync flops, counters, `b`, `press`, `release_p` and `multi` all go to 0.
  - All channel FSMs go to IDLE.
  - Reset deasserting while a button is held: the press is re-debounced from scratch, so it is seen as a fresh press after the full latency.
- **Synchroniser:** s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
- **Per-channel FSM**, states IDLE, ARM_P, HELD, ARM_R:
  - IDLE (db=0): s2=1 → ARM_P with cnt=1; else stay.
  - ARM_P: s2=0 → IDLE, cnt=0 (glitch rejected). s2=1 and cnt==DEBOUNCE_CYCLES-1 → HELD, db<=1, cnt=0. Otherwise cnt++.
  - HELD (db=1): s2=0 → ARM_R with cnt=1.
  - ARM_R: s2=1 → HELD, cnt=0. s2=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE, db<=0, cnt=0. Otherwise cnt++.
- **Counter width:** $clog2(DEBOUNCE_CYCLES). No wrap is possible, because the counter clears at the terminal count.
- **Latency:**
  - A raw edge captured at clock edge 0 appears on `b` after edge DEBOUNCE_CYCLES+1, i.e. 5 cycles for D=4.
  - A stable pulse of DEBOUNCE_CYCLES or more cycles at s2 always propagates.
  - Any pulse shorter than DEBOUNCE_CYCLES cycles never propagates.
- **press / release_p:**
  - Registered, asserted in the same cycle `b` changes, high for exactly 1 cycle.
  - Never asserted together on one bit.
- **multi:** registered, equal to popcount(next db) ≥ 2, updated in the same cycle as `b`.
- **Independence:** channels are fully independent. Simultaneous raw edges on several bits produce simultaneous `b` changes.
- **Hold-off:** there is no auto-repeat. A held button gives exactly one `press` pulse.

Optional Feature:
- Macro: GUESS_ONEHOT_LOCK_EN.
- **Defined** (anti-cheat):
  - While `multi`=1, `b` is forced to all-zero and `press` is suppressed.
  - When the vector returns to one or zero bits set, `b` resumes the debounced value on the next update.
  - No `press` pulse is generated for a button that became visible only because another was released.
  - `release_p` is unaffected.
- **Undefined:** `b` is the raw debounced vector, and `multi` is informational only.

Decomposition:
- Package guess_pkg:
  - localparam N_BTN=4.
  - typedef logic [N_BTN-1:0] btn_vec_t.
  - typedef enum {IDLE, ARM_P, HELD, ARM_R} deb_state_t.
- Sub-module btn_debounce: one channel (synchroniser + FSM + counter + press/release pulse), parameterised by DEBOUNCE_CYCLES.
  - Instantiated N_BTN times in a generate loop.
  - The top level adds popcount/multi and the optional lock.

Test Plan:
1. reset low for 2 cycles with btn_raw=4'b0001, then release reset → b=0 during reset; b=4'b0001 and press=4'b0001 for 1 cycle, 5 cycles after the first sampling edge.
2. btn_raw[2] glitch high for 3 cycles (D=4) → b, press and release_p stay 0000 throughout.
3. Hold 4'b1000 for 20 cycles, then release → exactly one press pulse; b=1000 until 5 cycles after release; exactly one release_p=1000 pulse.
4. Hold 4'b0010, then add bit 0 (4'b0011) → multi=1 when bit 0 resolves. Without the macro, b=0011. With GUESS_ONEHOT_LOCK_EN, b=0000 and no press on bit 0.
5. Bounce: btn_raw[1] toggles 1,0,1,0,1 every cycle, then stays 1 → b[1] rises exactly once, 5 cycles after the last 0→1; one press pulse.
6. Reset asserted mid ARM_P (cnt=2) → immediate b=0 and cnt=0. After reset deasserts with the button still held, the full 5-cycle latency applies again.
